// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save stream accumulator: state encoding,
// default geometry and the chunk-index width helper.
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 64;
    localparam int unsigned DEF_CHUNK = 16;
    localparam int unsigned DEF_CNT_W = 16;

    // Width of a counter that walks nchunk chunks; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

    localparam int unsigned DEF_NCHUNK = DEF_WIDTH / DEF_CHUNK;
    localparam int unsigned DEF_IDX_W  = idx_width(DEF_NCHUNK);

endpackage

// File: rtl/csa_row.sv
// One WIDTH-bit 3:2 carry-save compressor row. The carry vector is already
// weighted (shifted up one place, bit 0 zero); the MSB majority falls off.
module csa_row #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH-2:0] maj;

    // Full-adder sum on every bit, majority on all bits that survive the shift.
    always_comb begin
        s   = x ^ y ^ z;
        maj = (x[WIDTH-2:0] & y[WIDTH-2:0]) |
              (x[WIDTH-2:0] & z[WIDTH-2:0]) |
              (y[WIDTH-2:0] & z[WIDTH-2:0]);
        c   = {maj, 1'b0};
    end

endmodule

// File: rtl/csa_stream_accumulator.sv
// Streams operands into a redundant sum/carry pair, then resolves the pair
// with a chunked carry-propagate add and offers one result per packet.
module csa_stream_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = idx_width(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] sum_vec;
    logic [WIDTH-1:0] carry_vec;
    logic [WIDTH-1:0] result;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] chunk_idx;
    logic             cy;

    logic [WIDTH-1:0] row_s;
    logic [WIDTH-1:0] row_c;
    logic             in_hs;
    int unsigned      base;
    logic [CHUNK-1:0] s_chunk;
    logic [CHUNK-1:0] c_chunk;
    logic [CHUNK:0]   chunk_sum;

    csa_row #(
        .WIDTH (WIDTH)
    ) u_row (
        .x (sum_vec),
        .y (carry_vec),
        .z (in_data),
        .s (row_s),
        .c (row_c)
    );

    // Handshake/status outputs; ready is masked while reset is held.
    always_comb begin
        in_ready  = rst_n && (state == ST_ACCUM);
        in_hs     = in_valid && in_ready;
        out_valid = (state == ST_OUTPUT);
        out_sum   = result;
        out_count = count;
    end

    // Select the current chunk of the pair and add it with the running carry.
    always_comb begin
        base      = 32'(chunk_idx) * CHUNK;
        s_chunk   = sum_vec[base +: CHUNK];
        c_chunk   = carry_vec[base +: CHUNK];
        chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, cy};
    end

    // Accumulate / resolve / present state machine with all datapath state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            sum_vec   <= '0;
            carry_vec <= '0;
            result    <= '0;
            count     <= '0;
            chunk_idx <= '0;
            cy        <= 1'b0;
        end else begin
            unique case (state)
                ST_ACCUM: begin
                    if (in_hs) begin
                        sum_vec   <= row_s;
                        carry_vec <= row_c;
                        if (count != {CNT_W{1'b1}}) begin
                            count <= count + CNT_W'(1);
                        end
                        if (in_last) begin
                            state     <= ST_RESOLVE;
                            chunk_idx <= '0;
                            cy        <= 1'b0;
                        end
                    end
                end
                ST_RESOLVE: begin
                    result[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    // Carry out of the top chunk is the mod-2^WIDTH overflow.
                    cy <= chunk_sum[CHUNK];
                    if (chunk_idx == LAST_IDX) begin
                        state <= ST_OUTPUT;
                    end else begin
                        chunk_idx <= chunk_idx + IDX_W'(1);
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        sum_vec   <= '0;
                        carry_vec <= '0;
                        count     <= '0;
                        state     <= ST_ACCUM;
                    end
                end
                default: begin
                    state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule
